// File: rtl/fpro_bus_pkg.sv
// fpro_bus_pkg: shared FPro bus types, widths and the bridge address decode.
package fpro_bus_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} brg_state_t;
    localparam int FP_ADDR_W = 21;
    localparam int FP_DATA_W = 32;
    localparam int BRG_SEL_BIT = 23;
    localparam logic [31:0] BRG_BASE = 32'hC000_0000;
    localparam logic [31:0] RD_DEFAULT = 32'hFFFF_FFFF;
    // returns {hit, video_sel}; only the top byte of base takes part in the window match
    function automatic logic [1:0] brg_decode(input logic [31:0] addr, input logic [31:0] base);
        return {((addr ^ base) & 32'hFF00_0000) == 32'h0, addr[BRG_SEL_BIT]};
    endfunction
endpackage

// File: rtl/chu_mcs_fpro_bridge_if.sv
// chu_mcs_fpro_bridge_if: MCS IO bus plus FPro bus as seen by the bridge.
interface chu_mcs_fpro_bridge_if;
    import fpro_bus_pkg::*;
    logic                 io_addr_strobe;
    logic                 io_read_strobe;
    logic                 io_write_strobe;
    logic [31:0]          io_address;
    logic [3:0]           io_byte_enable;
    logic [31:0]          io_write_data;
    logic [31:0]          io_read_data;
    logic                 io_ready;
    logic                 fp_mmio_cs;
    logic                 fp_video_cs;
    logic                 fp_wr;
    logic                 fp_rd;
    logic [FP_ADDR_W-1:0] fp_addr;
    logic [FP_DATA_W-1:0] fp_wr_data;
    logic [FP_DATA_W-1:0] fp_mmio_rd_data;
    logic [FP_DATA_W-1:0] fp_video_rd_data;
    modport master (
        output io_addr_strobe, io_read_strobe, io_write_strobe, io_address, io_byte_enable,
               io_write_data, fp_mmio_rd_data, fp_video_rd_data,
        input  io_read_data, io_ready, fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data
    );
    modport slave (
        input  io_addr_strobe, io_read_strobe, io_write_strobe, io_address, io_byte_enable,
               io_write_data, fp_mmio_rd_data, fp_video_rd_data,
        output io_read_data, io_ready, fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data
    );
endinterface

// File: rtl/chu_mcs_fpro_bridge.sv
// chu_mcs_fpro_bridge: MCS IO bus to FPro bridge, fixed 2-cycle latency, sticky error flag.
module chu_mcs_fpro_bridge
    import fpro_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    chu_mcs_fpro_bridge_if.slave  bus,
    output logic                  brg_err
);
    brg_state_t           state;
    logic [FP_ADDR_W-1:0] addr_q;
    logic [FP_DATA_W-1:0] wd_q;
    logic [31:0]          rdata_q;
    logic                 rd_q, wr_q, vid_q, err_q;
    logic [1:0]           dec;
    logic                 ok_rd, ok_wr, unused;
    assign unused = ^bus.io_address[1:0];
    assign dec = brg_decode(bus.io_address, BRG_BASE);
    assign ok_rd = dec[1] && bus.io_read_strobe && !bus.io_write_strobe;
    assign ok_wr = dec[1] && bus.io_write_strobe && !bus.io_read_strobe && bus.io_byte_enable == 4'hF;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            vid_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (bus.io_addr_strobe && state != IDLE)
                err_q <= 1'b1;
            case (state)
                IDLE: if (bus.io_addr_strobe) begin
                    addr_q <= bus.io_address[FP_ADDR_W+1:2];
                    wd_q   <= bus.io_write_data;
                    rd_q   <= ok_rd;
                    wr_q   <= ok_wr;
                    vid_q  <= dec[0];
                    state  <= ACCESS;
                end
                ACCESS: begin
                    // rejected requests are neither rd_q nor wr_q
                    if (rd_q)
                        rdata_q <= vid_q ? bus.fp_video_rd_data : bus.fp_mmio_rd_data;
                    else if (!wr_q) begin
                        rdata_q <= RD_DEFAULT;
                        err_q   <= 1'b1;
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.fp_rd        = state == ACCESS && rd_q;
    assign bus.fp_wr        = state == ACCESS && wr_q;
    assign bus.fp_mmio_cs   = state == ACCESS && (rd_q || wr_q) && !vid_q;
    assign bus.fp_video_cs  = state == ACCESS && (rd_q || wr_q) && vid_q;
    assign bus.fp_addr      = addr_q;
    assign bus.fp_wr_data   = wd_q;
    assign bus.io_read_data = rdata_q;
    assign bus.io_ready     = state == DONE;
    assign brg_err          = err_q;
endmodule
